pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; used for the performance counters.
REQ-002 SHALL have parameter IMEM_LAT, default 1, range 1..4: cycles of instruction-fetch latency; wrong-path fetches in flight after a redirect.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, range 1..65535: maximum data-memory wait cycles.
REQ-004 SHALL have ports:
  i_clk  in  1  clock; all state updates on the rising edge
  i_arst_n  in  1  asynchronous, active-low reset
  i_id_rs1_addr, i_id_rs2_addr  in  5 each  source registers of the ID-stage instruction
  i_id_use_rs1, i_id_use_rs2  in  1 each  ID-stage instruction reads rs1 / rs2
  i_ex_mem_read  in  1  EX-stage instruction is a load
  i_ex_rd_addr  in  5  EX-stage destination register
  i_mem_branch_taken  in  1  MEM-stage branch resolved taken
  i_mem_jump  in  1  MEM-stage instruction is JAL/JALR
  i_mem_dmem_req  in  1  MEM-stage instruction is a load or store
  i_dmem_ready  in  1  data memory completes the access this cycle
  o_pc_stall, o_ifid_stall, o_idex_stall, o_exmem_stall  out  1 each  hold the PC / stage register
  o_ifid_flush, o_idex_flush, o_exmem_flush, o_memwb_flush  out  1 each  load a bubble into the stage register
  o_redirect  out  1  PC takes the branch/jump target this cycle
  o_mem_timeout  out  1  sticky data-memory timeout error
  o_stall_cycles  out  N  saturating count of stall cycles
  o_flush_events  out  16  saturating count of redirects

Function
REQ-005 SHALL implement FSM states RUN, MEM_WAIT and REDIRECT, with RUN as the reset state.
REQ-006 Load-use hazard SHALL be i_ex_mem_read && i_ex_rd_addr!=0 && ((i_id_use_rs1 && rs1==rd) || (i_id_use_rs2 && rs2==rd)).
REQ-007 Redirect request SHALL be i_mem_branch_taken || i_mem_jump.
REQ-008 Memory miss SHALL be i_mem_dmem_req && !i_dmem_ready.
REQ-009 Priority within a cycle SHALL be: memory miss, then redirect, then load-use.
REQ-010 All stall/flush/redirect outputs SHALL be combinational from the inputs and the current state, taking effect in the same cycle.
REQ-011 RUN, memory miss SHALL:
  - assert pc/ifid/idex/exmem stall and memwb flush;
  - go to MEM_WAIT;
  - load the wait counter with 1.
REQ-012 RUN, redirect without memory miss SHALL:
  - assert o_redirect and ifid/idex/exmem flush;
  - go to REDIRECT if IMEM_LAT>1, with the kill counter loaded with IMEM_LAT-1; otherwise stay in RUN.
REQ-013 RUN, load-use only SHALL assert pc_stall and ifid_stall and idex_flush, inserting a 1-cycle bubble, with no state change.
REQ-014 MEM_WAIT SHALL:
  - assert the same outputs as REQ-011 while !i_dmem_ready;
  - on i_dmem_ready, deassert all outputs that cycle and return to RUN.
REQ-015 A redirect or load-use present during MEM_WAIT SHALL be ignored, since the stages are held, and SHALL be re-evaluated in RUN.
REQ-016 When the MEM_WAIT wait counter reaches MEM_TIMEOUT without ready, the block SHALL:
  - set o_mem_timeout, which stays set until reset;
  - release the stall;
  - return to RUN.
REQ-017 REDIRECT SHALL:
  - assert only ifid_flush, to kill wrong-path fetches;
  - decrement the kill counter each cycle;
  - return to RUN when the counter reaches 1.
REQ-018 In REDIRECT, load-use SHALL be masked because ID holds a bubble.
REQ-019 A new redirect or memory miss in REDIRECT SHALL be handled per REQ-011/REQ-012, with redirect reloading the kill counter.
REQ-020 o_stall_cycles SHALL increment in every cycle in which o_pc_stall=1, saturating at 2^N-1.
REQ-021 o_flush_events SHALL increment once per o_redirect cycle, saturating at 0xFFFF.
REQ-022 Stall and flush SHALL never both be asserted on the same stage register.

Reset
REQ-023 While i_arst_n=0, the block SHALL:
  - be in state RUN;
  - clear the wait and kill counters, o_stall_cycles, o_flush_events and o_mem_timeout;
  - force all stall/flush/redirect outputs to 0 regardless of inputs.
REQ-024 Reset asserted mid-MEM_WAIT or mid-REDIRECT SHALL abort immediately, with no residual stall or flush after release.
REQ-025 The first clock edge after reset release SHALL evaluate the inputs normally.

Verification
REQ-026 Load-use: EX load rd=5, ID use_rs2 with rs2=5 -> 1 cycle of pc/ifid stall + idex flush; o_stall_cycles=1. Same stimulus with rd=0 -> no stall.
REQ-027 Memory wait: dmem_req with ready low for 3 cycles then high -> stalls for 3 cycles, memwb flush for 3 cycles, release on the ready cycle; o_stall_cycles=3.
REQ-028 Redirect with IMEM_LAT=3: branch taken -> cycle 0 redirect + 3 flushes, cycles 1-2 ifid_flush only, then RUN; o_flush_events=1.
REQ-029 Simultaneous events: memory miss + redirect + load-use in the same cycle -> MEM_WAIT outputs only; redirect fires on the cycle after ready.
REQ-030 Timeout: MEM_TIMEOUT=4, ready never asserted -> o_mem_timeout=1 after 4 wait cycles, stall released, flag persists.
REQ-031 Reset mid-REDIRECT (IMEM_LAT=4, cycle 1) -> outputs 0 and counters 0 immediately; after release, no ifid_flush.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, data-memory wait stalls, redirect flushes.
// Stall/flush/redirect outputs are combinational from the inputs and the current state; counters and the timeout flag are registered.
module pipeline_hazard_ctrl #(
   parameter int N           = 32,
   parameter int IMEM_LAT    = 1,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic         i_clk,
   input  logic         i_arst_n,
   input  logic [4:0]   i_id_rs1_addr,
   input  logic [4:0]   i_id_rs2_addr,
   input  logic         i_id_use_rs1,
   input  logic         i_id_use_rs2,
   input  logic         i_ex_mem_read,
   input  logic [4:0]   i_ex_rd_addr,
   input  logic         i_mem_branch_taken,
   input  logic         i_mem_jump,
   input  logic         i_mem_dmem_req,
   input  logic         i_dmem_ready,
   output logic         o_pc_stall,
   output logic         o_ifid_stall,
   output logic         o_idex_stall,
   output logic         o_exmem_stall,
   output logic         o_ifid_flush,
   output logic         o_idex_flush,
   output logic         o_exmem_flush,
   output logic         o_memwb_flush,
   output logic         o_redirect,
   output logic         o_mem_timeout,
   output logic [N-1:0] o_stall_cycles,
   output logic [15:0]  o_flush_events
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

   localparam logic [2:0]  KILL_INIT = 3'(IMEM_LAT - 1);
   localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt, wait_nxt;
   logic [2:0]  kill_cnt, kill_nxt;
   logic        timeout_set;

   logic pc_stall, ifid_stall, idex_stall, exmem_stall;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, redirect;

   logic load_use, redir_req, mem_miss;

   assign load_use  = i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
                      ((i_id_use_rs1 && (i_id_rs1_addr == i_ex_rd_addr)) ||
                       (i_id_use_rs2 && (i_id_rs2_addr == i_ex_rd_addr)));
   assign redir_req = i_mem_branch_taken || i_mem_jump;
   assign mem_miss  = i_mem_dmem_req && !i_dmem_ready;

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      kill_nxt    = kill_cnt;
      timeout_set = 1'b0;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      redirect    = 1'b0;

      case (state)
         RUN, REDIRECT: begin
            // Default REDIRECT action; overridden below by a newer miss or redirect
            if (state == REDIRECT) begin
               ifid_flush = 1'b1;
               if (kill_cnt <= 3'd1) state_nxt = RUN;
               else                  kill_nxt  = kill_cnt - 3'd1;
            end
            if (mem_miss) begin
               ifid_flush  = 1'b0;
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_stall  = 1'b1;
               exmem_stall = 1'b1;
               memwb_flush = 1'b1;
               state_nxt   = MEM_WAIT;
               wait_nxt    = 16'd1;
            end else if (redir_req) begin
               redirect    = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
               if (IMEM_LAT > 1) begin
                  state_nxt = REDIRECT;
                  kill_nxt  = KILL_INIT;
               end else begin
                  state_nxt = RUN;
               end
            end else if (load_use && (state == RUN)) begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (i_dmem_ready) begin
               state_nxt = RUN;
            end else if (wait_cnt >= TMO_LIMIT) begin
               timeout_set = 1'b1;
               state_nxt   = RUN;
            end else begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_stall  = 1'b1;
               exmem_stall = 1'b1;
               memwb_flush = 1'b1;
               wait_nxt    = wait_cnt + 16'd1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // Reset must silence the outputs even though the inputs keep driving the decode
   assign o_pc_stall    = pc_stall    & i_arst_n;
   assign o_ifid_stall  = ifid_stall  & i_arst_n;
   assign o_idex_stall  = idex_stall  & i_arst_n;
   assign o_exmem_stall = exmem_stall & i_arst_n;
   assign o_ifid_flush  = ifid_flush  & i_arst_n;
   assign o_idex_flush  = idex_flush  & i_arst_n;
   assign o_exmem_flush = exmem_flush & i_arst_n;
   assign o_memwb_flush = memwb_flush & i_arst_n;
   assign o_redirect    = redirect    & i_arst_n;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state          <= RUN;
         wait_cnt       <= 16'd0;
         kill_cnt       <= 3'd0;
         o_mem_timeout  <= 1'b0;
         o_stall_cycles <= '0;
         o_flush_events <= 16'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         kill_cnt <= kill_nxt;
         if (timeout_set)
            o_mem_timeout <= 1'b1;
         if (o_pc_stall && (o_stall_cycles != '1))
            o_stall_cycles <= o_stall_cycles + 1'b1;
         if (o_redirect && (o_flush_events != 16'hFFFF))
            o_flush_events <= o_flush_events + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two controllers (IMEM_LAT=3/MEM_TIMEOUT=4/N=32 and IMEM_LAT=4/MEM_TIMEOUT=255/N=4) on shared stimulus.
module tb_pipeline_hazard_ctrl;

   // Control vector bit order: pc_s ifid_s idex_s exmem_s ifid_f idex_f exmem_f memwb_f redir
   localparam logic [8:0] NONE = 9'h000;
   localparam logic [8:0] LU   = 9'h188;
   localparam logic [8:0] MW   = 9'h1E2;
   localparam logic [8:0] RD   = 9'h01D;
   localparam logic [8:0] KF   = 9'h010;

   logic       i_clk;
   logic       i_arst_n;
   logic [4:0] rs1, rs2, rd;
   logic       use_rs1, use_rs2, ex_load, br_taken, jump, dmem_req, dmem_ready;

   logic [8:0]  ctl0, ctl1;
   logic        tmo0, tmo1;
   logic [31:0] stall0;
   logic [3:0]  stall1;
   logic [15:0] flush0, flush1;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(.N(32), .IMEM_LAT(3), .MEM_TIMEOUT(4)) dut0 (
      .i_clk(i_clk), .i_arst_n(i_arst_n),
      .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
      .i_id_use_rs1(use_rs1), .i_id_use_rs2(use_rs2),
      .i_ex_mem_read(ex_load), .i_ex_rd_addr(rd),
      .i_mem_branch_taken(br_taken), .i_mem_jump(jump),
      .i_mem_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
      .o_pc_stall(ctl0[8]), .o_ifid_stall(ctl0[7]), .o_idex_stall(ctl0[6]), .o_exmem_stall(ctl0[5]),
      .o_ifid_flush(ctl0[4]), .o_idex_flush(ctl0[3]), .o_exmem_flush(ctl0[2]), .o_memwb_flush(ctl0[1]),
      .o_redirect(ctl0[0]), .o_mem_timeout(tmo0),
      .o_stall_cycles(stall0), .o_flush_events(flush0)
   );

   pipeline_hazard_ctrl #(.N(4), .IMEM_LAT(4), .MEM_TIMEOUT(255)) dut1 (
      .i_clk(i_clk), .i_arst_n(i_arst_n),
      .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
      .i_id_use_rs1(use_rs1), .i_id_use_rs2(use_rs2),
      .i_ex_mem_read(ex_load), .i_ex_rd_addr(rd),
      .i_mem_branch_taken(br_taken), .i_mem_jump(jump),
      .i_mem_dmem_req(dmem_req), .i_dmem_ready(dmem_ready),
      .o_pc_stall(ctl1[8]), .o_ifid_stall(ctl1[7]), .o_idex_stall(ctl1[6]), .o_exmem_stall(ctl1[5]),
      .o_ifid_flush(ctl1[4]), .o_idex_flush(ctl1[3]), .o_exmem_flush(ctl1[2]), .o_memwb_flush(ctl1[1]),
      .o_redirect(ctl1[0]), .o_mem_timeout(tmo1),
      .o_stall_cycles(stall1), .o_flush_events(flush1)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      use_rs1 = 1'b0; use_rs2 = 1'b0; ex_load = 1'b0;
      br_taken = 1'b0; jump = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] dst);
      ex_load = 1'b1; rd = dst; use_rs2 = 1'b1; rs2 = 5'd5; rs1 = 5'd9; use_rs1 = 1'b0;
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      idle();
      i_arst_n = 1'b0;
      step();
      // Inputs active during reset must not reach the outputs
      set_load_use(5'd5); dmem_req = 1'b1; br_taken = 1'b1;
      #1;
      chk("rst_ctl0", 32'(ctl0), 32'(NONE));
      chk("rst_ctl1", 32'(ctl1), 32'(NONE));
      chk("rst_stall0", stall0, 32'd0);
      chk("rst_flush0", 32'(flush0), 32'd0);
      chk("rst_tmo0", 32'(tmo0), 32'd0);
      idle();
      step();
      i_arst_n = 1'b1;

      // Load-use: rd=5 matches rs2
      set_load_use(5'd5); #1;
      chk("lu_ctl0", 32'(ctl0), 32'(LU));
      chk("lu_ctl1", 32'(ctl1), 32'(LU));
      step(); idle(); #1;
      chk("lu_after", 32'(ctl0), 32'(NONE));
      chk("lu_stall0", stall0, 32'd1);
      set_load_use(5'd0); #1;
      chk("lu_rd0", 32'(ctl0), 32'(NONE));
      set_load_use(5'd9); use_rs2 = 1'b0; #1;
      chk("lu_rs1_unused", 32'(ctl0), 32'(NONE));
      use_rs1 = 1'b1; #1;
      chk("lu_rs1", 32'(ctl0), 32'(LU));
      idle(); #1;

      // Memory wait: 3 cycles not ready, then ready
      dmem_req = 1'b1; dmem_ready = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         chk("mw_ctl0", 32'(ctl0), 32'(MW));
         chk("mw_ctl1", 32'(ctl1), 32'(MW));
         step();
      end
      dmem_ready = 1'b1; #1;
      chk("mw_rdy_ctl0", 32'(ctl0), 32'(NONE));
      chk("mw_rdy_ctl1", 32'(ctl1), 32'(NONE));
      step(); idle(); #1;
      chk("mw_stall0", stall0, 32'd4);
      chk("mw_stall1", 32'(stall1), 32'd4);

      // Redirect; load-use masked while killing wrong-path fetches
      br_taken = 1'b1; #1;
      chk("rd_c0_ctl0", 32'(ctl0), 32'(RD));
      chk("rd_c0_ctl1", 32'(ctl1), 32'(RD));
      step(); idle(); set_load_use(5'd5); #1;
      chk("rd_c1_ctl0", 32'(ctl0), 32'(KF));
      chk("rd_c1_ctl1", 32'(ctl1), 32'(KF));
      step(); idle(); #1;
      chk("rd_c2_ctl0", 32'(ctl0), 32'(KF));
      chk("rd_c2_ctl1", 32'(ctl1), 32'(KF));
      step(); #1;
      chk("rd_c3_ctl0", 32'(ctl0), 32'(NONE));
      chk("rd_c3_ctl1", 32'(ctl1), 32'(KF));
      step(); #1;
      chk("rd_c4_ctl1", 32'(ctl1), 32'(NONE));
      chk("rd_flush0", 32'(flush0), 32'd1);
      chk("rd_flush1", 32'(flush1), 32'd1);

      // Simultaneous miss + redirect + load-use
      set_load_use(5'd5); br_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0; #1;
      chk("sim_c0", 32'(ctl0), 32'(MW));
      step(); #1;
      chk("sim_c1", 32'(ctl1), 32'(MW));
      step(); dmem_ready = 1'b1; #1;
      chk("sim_rdy0", 32'(ctl0), 32'(NONE));
      chk("sim_rdy1", 32'(ctl1), 32'(NONE));
      step(); dmem_req = 1'b0; dmem_ready = 1'b0; #1;
      chk("sim_rd0", 32'(ctl0), 32'(RD));
      chk("sim_rd1", 32'(ctl1), 32'(RD));
      step(); idle(); #1;
      chk("sim_k1", 32'(ctl0), 32'(KF));
      step(); #1;
      chk("sim_k2", 32'(ctl1), 32'(KF));
      step(); #1;
      chk("sim_k3_ctl0", 32'(ctl0), 32'(NONE));
      chk("sim_k3_ctl1", 32'(ctl1), 32'(KF));
      step(); #1;
      chk("sim_stall0", stall0, 32'd6);
      chk("sim_flush0", 32'(flush0), 32'd2);

      // Miss arriving during REDIRECT takes over
      br_taken = 1'b1; #1;
      chk("rm_rd", 32'(ctl0), 32'(RD));
      step(); idle(); dmem_req = 1'b1; #1;
      chk("rm_mw0", 32'(ctl0), 32'(MW));
      chk("rm_mw1", 32'(ctl1), 32'(MW));
      step(); dmem_ready = 1'b1; #1;
      chk("rm_rdy", 32'(ctl0), 32'(NONE));
      step(); idle(); #1;
      chk("rm_run0", 32'(ctl0), 32'(NONE));
      chk("rm_run1", 32'(ctl1), 32'(NONE));
      chk("rm_flush0", 32'(flush0), 32'd3);

      // Timeout on dut0 (limit 4); dut1 keeps waiting
      dmem_req = 1'b1; dmem_ready = 1'b0; #1;
      for (int i = 0; i < 4; i++) begin
         chk("to_wait0", 32'(ctl0), 32'(MW));
         step();
      end
      chk("to_rel0", 32'(ctl0), 32'(NONE));
      chk("to_hold1", 32'(ctl1), 32'(MW));
      chk("to_flag_pre", 32'(tmo0), 32'd0);
      step(); dmem_req = 1'b0; dmem_ready = 1'b1; #1;
      chk("to_flag0", 32'(tmo0), 32'd1);
      chk("to_flag1", 32'(tmo1), 32'd0);
      chk("to_rdy1", 32'(ctl1), 32'(NONE));
      step(); idle(); #1;
      chk("to_sticky", 32'(tmo0), 32'd1);
      chk("to_stall0", stall0, 32'd11);
      chk("to_stall1", 32'(stall1), 32'd12);

      // Continuous load-use drives dut1's 4-bit counter into saturation
      set_load_use(5'd5); #1;
      for (int i = 0; i < 5; i++) begin
         chk("sat_lu", 32'(ctl0), 32'(LU));
         step();
      end
      idle(); #1;
      chk("sat_stall0", stall0, 32'd16);
      chk("sat_stall1", 32'(stall1), 32'd15);

      // Reset in the middle of REDIRECT on dut1
      br_taken = 1'b1; #1;
      chk("rr_rd1", 32'(ctl1), 32'(RD));
      step(); idle(); #1;
      chk("rr_kf1", 32'(ctl1), 32'(KF));
      i_arst_n = 1'b0; set_load_use(5'd5); #1;
      chk("rr_ctl0", 32'(ctl0), 32'(NONE));
      chk("rr_ctl1", 32'(ctl1), 32'(NONE));
      chk("rr_stall1", 32'(stall1), 32'd0);
      chk("rr_flush1", 32'(flush1), 32'd0);
      chk("rr_tmo0", 32'(tmo0), 32'd0);
      idle();
      step();
      i_arst_n = 1'b1; set_load_use(5'd5); #1;
      chk("rr_rel_ctl0", 32'(ctl0), 32'(LU));
      chk("rr_rel_ctl1", 32'(ctl1), 32'(LU));
      step(); idle(); #1;
      chk("rr_idle1", 32'(ctl1), 32'(NONE));
      chk("rr_stall0", stall0, 32'd1);
      chk("rr_stall1", 32'(stall1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
